// File: rtl/state_code_serializer_if.sv
// ----------------------------------------------------------------------------
// state_code_serializer_if
//   Bundles the frame request handshake and the 3-bit state-code bus of the
//   state-code link transmitter.
//
//   Signals
//     start       frame request, accepted only while ready=1
//     dataIn      WIDTH-bit frame data, sampled on the accepting cycle
//     ready       1 = transmitter idle, start will be accepted
//     state       3-bit code bus (IDLE=001 S0=010 S1=100 S2=110 S3=101)
//     stateValid  1 while state carries a data/parity symbol
//     done        1-cycle pulse when a frame completes
//
//   Modports
//     master  frame source (drives start/dataIn, observes the bus)
//     slave   serializer (samples start/dataIn, drives the bus)
// ----------------------------------------------------------------------------
interface state_code_serializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dataIn;
    logic             ready;
    logic [2:0]       state;
    logic             stateValid;
    logic             done;

    modport master (
        output start,
        output dataIn,
        input  ready,
        input  state,
        input  stateValid,
        input  done
    );

    modport slave (
        input  start,
        input  dataIn,
        output ready,
        output state,
        output stateValid,
        output done
    );
endinterface

// File: rtl/state_code_serializer.sv
// ----------------------------------------------------------------------------
// state_code_serializer
//   Transmit side of the 3-bit state-code link. A parallel word is shifted out
//   MSB first, one code per bit, each code held BIT_CYCLES clocks. A 0 bit is
//   sent as S0/S1 and a 1 bit as S2/S3, alternating per bit so that repeated
//   bits still change the bus. The bus rests at IDLE between frames.
//
//   Parameters
//     WIDTH       data bits per frame (>=1)
//     BIT_CYCLES  clocks each code is held (>=1)
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   synchronous reset, active-high
//     bus   slave modport of state_code_serializer_if (start, dataIn, ready,
//           state, stateValid, done)
//
//   Build option
//     STATE_SER_PARITY_EN  when defined, an extra even-parity symbol (PAR)
//                          follows the data bits; frame = WIDTH+1 symbols.
//                          When undefined there is no PAR state or parity
//                          logic; frame = WIDTH symbols.
// ----------------------------------------------------------------------------
module state_code_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    state_code_serializer_if.slave bus
);

    localparam logic [2:0] CODE_IDLE = 3'b001;
    localparam logic [2:0] CODE_S0   = 3'b010;
    localparam logic [2:0] CODE_S1   = 3'b100;
    localparam logic [2:0] CODE_S2   = 3'b110;
    localparam logic [2:0] CODE_S3   = 3'b101;

    localparam int BW = $clog2(WIDTH + 1);
    localparam int HW = $clog2(BIT_CYCLES + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND
`ifdef STATE_SER_PARITY_EN
        , ST_PAR
`endif
    } fsm_t;

    // Bit value plus alternation phase select one of the four symbol codes.
    function automatic logic [2:0] code_of(input logic b, input logic a);
        case ({b, a})
            2'b00:   code_of = CODE_S0;
            2'b01:   code_of = CODE_S1;
            2'b10:   code_of = CODE_S2;
            default: code_of = CODE_S3;
        endcase
    endfunction

    fsm_t             fsm_q;
    fsm_t             fsm_d;
    logic [WIDTH-1:0] shift_q;
    logic             alt_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [HW-1:0]    hold_cnt_q;
    logic             done_q;
`ifdef STATE_SER_PARITY_EN
    logic             parity_q;
`endif

    logic hold_end;
    logic last_bit;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        fsm_d          = fsm_q;
        bus.state      = CODE_IDLE;
        bus.stateValid = 1'b0;
        bus.ready      = 1'b0;
        bus.done       = 1'b0;
        hold_end       = (hold_cnt_q == HOLD_LAST);
        last_bit       = (bit_cnt_q == BIT_LAST);

        unique case (fsm_q)
            ST_IDLE: begin
                bus.ready = 1'b1;
                // done_q is only ever set on the edge that enters IDLE, so
                // this yields exactly one pulse per completed frame.
                bus.done  = done_q;
                if (bus.start) begin
                    fsm_d = ST_SEND;
                end
            end
            ST_SEND: begin
                bus.state      = code_of(shift_q[WIDTH-1], alt_q);
                bus.stateValid = 1'b1;
                if (hold_end && last_bit) begin
`ifdef STATE_SER_PARITY_EN
                    fsm_d = ST_PAR;
`else
                    fsm_d = ST_IDLE;
`endif
                end
            end
`ifdef STATE_SER_PARITY_EN
            ST_PAR: begin
                bus.state      = code_of(parity_q, alt_q);
                bus.stateValid = 1'b1;
                if (hold_end) begin
                    fsm_d = ST_IDLE;
                end
            end
`endif
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is cleared too, so a dropped frame
            // leaves no stale data behind; it is a handful of flops, not RAM.
            fsm_q      <= ST_IDLE;
            shift_q    <= '0;
            alt_q      <= 1'b0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef STATE_SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            done_q <= (fsm_q != ST_IDLE) && (fsm_d == ST_IDLE);

            unique case (fsm_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_q    <= bus.dataIn;
                        alt_q      <= 1'b0;
                        bit_cnt_q  <= '0;
                        hold_cnt_q <= '0;
`ifdef STATE_SER_PARITY_EN
                        parity_q   <= ^bus.dataIn;
`endif
                    end
                end
                ST_SEND: begin
                    if (hold_end) begin
                        hold_cnt_q <= '0;
                        // alt also flips after the last bit: the parity
                        // symbol continues the alternation.
                        alt_q      <= ~alt_q;
                        shift_q    <= shift_q << 1;
                        // Counter saturates on the last bit; it is cleared
                        // at the next acceptance, so it never wraps.
                        if (!last_bit) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
`ifdef STATE_SER_PARITY_EN
                ST_PAR: begin
                    if (hold_end) begin
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_code_serializer.sv
// ----------------------------------------------------------------------------
// tb_state_code_serializer
//   Directed bench for state_code_serializer. Three instances share clk/rst:
//     u_dut1  WIDTH=4, BIT_CYCLES=1
//     u_dut3  WIDTH=4, BIT_CYCLES=3
//     u_dutw  WIDTH=1, BIT_CYCLES=1
//   Expected codes are hand-derived; parity symbols are expected only when
//   STATE_SER_PARITY_EN is defined.
// ----------------------------------------------------------------------------
module tb_state_code_serializer;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    state_code_serializer_if #(.WIDTH(4)) if1 ();
    state_code_serializer_if #(.WIDTH(4)) if3 ();
    state_code_serializer_if #(.WIDTH(1)) ifw ();

    state_code_serializer #(.WIDTH(4), .BIT_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    state_code_serializer #(.WIDTH(4), .BIT_CYCLES(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    state_code_serializer #(.WIDTH(1), .BIT_CYCLES(1)) u_dutw (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag,
                             input logic [2:0] st, input logic vld,
                             input logic rdy, input logic dn,
                             input logic [2:0] exp_st, input logic exp_vld,
                             input logic exp_rdy, input logic exp_dn);
        check({tag, "_state"}, 32'(st),  32'(exp_st));
        check({tag, "_valid"}, 32'(vld), 32'(exp_vld));
        check({tag, "_ready"}, 32'(rdy), 32'(exp_rdy));
        check({tag, "_done"},  32'(dn),  32'(exp_dn));
    endtask

    // One symbol cycle on u_dut1, then advance.
    task automatic sym1(input string tag, input logic [2:0] code);
        check_bus(tag, if1.state, if1.stateValid, if1.ready, if1.done,
                  code, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    task automatic idle1(input string tag, input logic dn);
        check_bus(tag, if1.state, if1.stateValid, if1.ready, if1.done,
                  3'b001, 1'b0, 1'b1, dn);
    endtask

    // One code on u_dut3, held for three cycles.
    task automatic sym3(input string tag, input logic [2:0] code);
        for (int h = 0; h < 3; h++) begin
            check_bus(tag, if3.state, if3.stateValid, if3.ready, if3.done,
                      code, 1'b1, 1'b0, 1'b0);
            step();
        end
    endtask

    // Full frame on u_dut1; codes packed first-symbol-in-MSBs.
    task automatic frame1(input string tag, input logic [3:0] data,
                          input logic [11:0] codes, input logic [2:0] par);
        if1.dataIn = data;
        if1.start  = 1'b1;
        step();
        if1.start  = 1'b0;
        if1.dataIn = ~data;
        for (int i = 0; i < 4; i++) begin
            sym1(tag, codes[11-3*i -: 3]);
        end
`ifdef STATE_SER_PARITY_EN
        sym1({tag, "_par"}, par);
`else
        if (par == 3'b000) $display("unexpected parity code argument");
`endif
        idle1({tag, "_done"}, 1'b1);
        step();
        idle1({tag, "_after"}, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        if1.start  = 1'b0;
        if1.dataIn = '0;
        if3.start  = 1'b0;
        if3.dataIn = '0;
        ifw.start  = 1'b0;
        ifw.dataIn = '0;
        step();
        step();

        // Reset state on all instances.
        idle1("rst1", 1'b0);
        check_bus("rst3", if3.state, if3.stateValid, if3.ready, if3.done,
                  3'b001, 1'b0, 1'b1, 1'b0);
        check_bus("rstw", ifw.state, ifw.stateValid, ifw.ready, ifw.done,
                  3'b001, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        step();
        idle1("rst1_rel", 1'b0);

        // 1: 1010 -> 110,100,110,100 (+ parity 0 at alt0 -> 010)
        frame1("t1", 4'b1010, {3'b110, 3'b100, 3'b110, 3'b100}, 3'b010);

        // 2: all zeros / all ones
        frame1("t2z", 4'b0000, {3'b010, 3'b100, 3'b010, 3'b100}, 3'b010);
        frame1("t2o", 4'b1111, {3'b110, 3'b101, 3'b110, 3'b101}, 3'b010);

        // 3: BIT_CYCLES=3, 1000 -> each code x3 (+ parity 1 at alt0 -> 110)
        if3.dataIn = 4'b1000;
        if3.start  = 1'b1;
        step();
        if3.start  = 1'b0;
        if3.dataIn = 4'b0111;
        sym3("t3_b3", 3'b110);
        sym3("t3_b2", 3'b100);
        sym3("t3_b1", 3'b010);
        sym3("t3_b0", 3'b100);
`ifdef STATE_SER_PARITY_EN
        sym3("t3_par", 3'b110);
`endif
        check_bus("t3_done", if3.state, if3.stateValid, if3.ready, if3.done,
                  3'b001, 1'b0, 1'b1, 1'b1);
        step();
        check_bus("t3_after", if3.state, if3.stateValid, if3.ready, if3.done,
                  3'b001, 1'b0, 1'b1, 1'b0);

        // 4: start mid-frame ignored, then back-to-back start in done cycle.
        if1.dataIn = 4'b1100;
        if1.start  = 1'b1;
        step();
        if1.start  = 1'b0;
        sym1("t4_s0", 3'b110);
        if1.start  = 1'b1;
        if1.dataIn = 4'b0011;
        sym1("t4_s1", 3'b101);
        if1.start  = 1'b0;
        sym1("t4_s2", 3'b010);
        sym1("t4_s3", 3'b100);
`ifdef STATE_SER_PARITY_EN
        sym1("t4_par", 3'b010);
`endif
        idle1("t4_done", 1'b1);
        if1.dataIn = 4'b0110;
        if1.start  = 1'b1;
        step();
        if1.start  = 1'b0;
        if1.dataIn = 4'b1001;
        sym1("t4b_s0", 3'b010);
        sym1("t4b_s1", 3'b101);
        sym1("t4b_s2", 3'b110);
        sym1("t4b_s3", 3'b100);
`ifdef STATE_SER_PARITY_EN
        sym1("t4b_par", 3'b010);
`endif
        idle1("t4b_done", 1'b1);
        step();

        // 5: reset during the third symbol drops the frame without done.
        if1.dataIn = 4'b1010;
        if1.start  = 1'b1;
        step();
        if1.start  = 1'b0;
        sym1("t5_s0", 3'b110);
        sym1("t5_s1", 3'b100);
        check("t5_s2_state", 32'(if1.state), 32'(3'b110));
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle1("t5_rst", 1'b0);
        step();
        idle1("t5_rst_hold", 1'b0);
        frame1("t5_new", 4'b0101, {3'b010, 3'b101, 3'b010, 3'b101}, 3'b010);

        // WIDTH=1: single-symbol frame (+ parity 1 at alt1 -> 101)
        ifw.dataIn = 1'b1;
        ifw.start  = 1'b1;
        step();
        ifw.start  = 1'b0;
        ifw.dataIn = 1'b0;
        check_bus("w1_s0", ifw.state, ifw.stateValid, ifw.ready, ifw.done,
                  3'b110, 1'b1, 1'b0, 1'b0);
        step();
`ifdef STATE_SER_PARITY_EN
        check_bus("w1_par", ifw.state, ifw.stateValid, ifw.ready, ifw.done,
                  3'b101, 1'b1, 1'b0, 1'b0);
        step();
`endif
        check_bus("w1_done", ifw.state, ifw.stateValid, ifw.ready, ifw.done,
                  3'b001, 1'b0, 1'b1, 1'b1);
        step();
        check_bus("w1_after", ifw.state, ifw.stateValid, ifw.ready, ifw.done,
                  3'b001, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
